clock_timekeeper: RTL and testbench

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

---
 rtl/clock_pkg.sv | 55 +++++
 rtl/clock_autorepeat.sv | 56 +++++
 rtl/clock_timekeeper.sv | 159 +++++++++++++++
 tb/tb_clock_timekeeper.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: state encoding, BCD limits and BCD helpers
// shared by the clock_timekeeper slice.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } clk_state_e;

   // Packed BCD {tens, units}
   localparam logic [5:0] BCD_HOUR_MAX = 6'h23;
   localparam logic [6:0] BCD_MIN_MAX  = 7'h59;
   localparam logic [6:0] BCD_SEC_MAX  = 7'h59;
   localparam logic [5:0] BCD_NOON     = 6'h12;

   function automatic logic [6:0] bcd_inc60(input logic [6:0] v);
      logic [6:0] r;
      if (v == BCD_MIN_MAX)
         r = 7'h00;
      else if (v[3:0] == 4'd9)
         r = {v[6:4] + 3'd1, 4'd0};
      else
         r = {v[6:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [5:0] bcd_inc24(input logic [5:0] v);
      logic [5:0] r;
      if (v == BCD_HOUR_MAX)
         r = 6'h00;
      else if (v[3:0] == 4'd9)
         r = {v[5:4] + 2'd1, 4'd0};
      else
         r = {v[5:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // 24-hour BCD hour -> 12-hour BCD hour (0 shows as 12)
   function automatic logic [5:0] hour_12h(input logic [5:0] h);
      logic [4:0] b;
      logic [5:0] r;
      b = 5'(h[5:4]) * 5'd10 + 5'(h[3:0]);
      if (b == 5'd0)
         b = 5'd12;
      else if (b > 5'd12)
         b = b - 5'd12;
      if (b >= 5'd10)
         r = {2'd1, 4'(b - 5'd10)};
      else
         r = {2'd0, 4'(b)};
      return r;
   endfunction

endpackage

// File: rtl/clock_autorepeat.sv
// clock_autorepeat: Up button edge detect plus autorepeat.
// Ports: clk_i, rst_ni (async low), up_i level, event_o 1-cycle pulse.
module clock_autorepeat
   import clock_pkg::*;
#(
   parameter int DELAY_CYC  = 16384,
   parameter int PERIOD_CYC = 4096
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic up_i,
   output logic event_o
);

   localparam int MAXC = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYC - 1);

   logic          up_q;
   logic          rep_q;
   logic          event_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] lim;

   // Initial hold uses the long delay, then the short period
   assign lim     = rep_q ? PER_LAST : DLY_LAST;
   assign event_o = event_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         up_q    <= 1'b0;
         rep_q   <= 1'b0;
         event_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         up_q    <= up_i;
         event_q <= 1'b0;
         if (!up_i) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
         end else if (!up_q) begin
            event_q <= 1'b1;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
         end else if (cnt_q == lim) begin
            event_q <= 1'b1;
            cnt_q   <= '0;
            rep_q   <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: BCD time-of-day clock with set mode and blink.
// Ports: i_Clock, i_Reset_n, i_Set_Pulse, i_Up_Level in; BCD digits,
// o_PM, o_Blank_Digits, o_Dot, o_Tick_1Hz, o_Day_Tick, o_Setting out.
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int CLK_FREQ_HZ       = 32768,
   parameter int HOUR_12           = 0,
   parameter int REPEAT_DELAY_CYC  = 16384,
   parameter int REPEAT_PERIOD_CYC = 4096
) (
   input  logic       i_Clock,
   input  logic       i_Reset_n,
   input  logic       i_Set_Pulse,
   input  logic       i_Up_Level,
   output logic [1:0] o_Hour_Tens,
   output logic [3:0] o_Hour_Units,
   output logic [2:0] o_Min_Tens,
   output logic [3:0] o_Min_Units,
   output logic [2:0] o_Sec_Tens,
   output logic [3:0] o_Sec_Units,
   output logic       o_PM,
   output logic [3:0] o_Blank_Digits,
   output logic       o_Dot,
   output logic       o_Tick_1Hz,
   output logic       o_Day_Tick,
   output logic       o_Setting
);

   localparam int PW    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam int HALF  = CLK_FREQ_HZ / 2;
   localparam int QUART = CLK_FREQ_HZ / 4;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ_HZ - 1);

   clk_state_e    state_q;
   logic [PW-1:0] presc_q;
   logic [31:0]   presc_w;
   logic [5:0]    hour_q, hour_d, hour_disp;
   logic [6:0]    min_q, min_d;
   logic [6:0]    sec_q, sec_d;
   logic          tick, inc_ev, blink, dot_run;
   logic          sec_wrap, min_wrap, midnight;
   logic          tick_q, day_q, dot_q;
   logic [3:0]    blank_q;

   clock_autorepeat #(
      .DELAY_CYC  (REPEAT_DELAY_CYC),
      .PERIOD_CYC (REPEAT_PERIOD_CYC)
   ) u_rep (
      .clk_i   (i_Clock),
      .rst_ni  (i_Reset_n),
      .up_i    (i_Up_Level),
      .event_o (inc_ev)
   );

   assign presc_w  = 32'(presc_q);
   assign tick     = (state_q == ST_RUN) && (presc_q == PRE_LAST);
   assign blink    = (presc_w % 32'(HALF)) >= 32'(QUART);
   assign dot_run  = presc_w < 32'(HALF);
   assign sec_wrap = sec_q == BCD_SEC_MAX;
   assign min_wrap = min_q == BCD_MIN_MAX;
   assign midnight = (hour_q == BCD_HOUR_MAX) && min_wrap && sec_wrap;

   // Tick carries run only in RUN; set edits never carry.
   // A Set pulse wins over a coincident Up event.
   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      sec_d  = sec_q;
      if (tick) begin
         sec_d = bcd_inc60(sec_q);
         if (sec_wrap) begin
            min_d = bcd_inc60(min_q);
            if (min_wrap)
               hour_d = bcd_inc24(hour_q);
         end
      end
      unique case (state_q)
         ST_SET_HOUR: begin
            if (!i_Set_Pulse && inc_ev)
               hour_d = bcd_inc24(hour_q);
         end
         ST_SET_MIN: begin
            if (i_Set_Pulse)
               sec_d = '0;
            else if (inc_ev)
               min_d = bcd_inc60(min_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= ST_RUN;
         presc_q <= '0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         tick_q  <= 1'b0;
         day_q   <= 1'b0;
         dot_q   <= 1'b0;
         blank_q <= '0;
      end else begin
         hour_q <= hour_d;
         min_q  <= min_d;
         sec_q  <= sec_d;
         tick_q <= tick;
         day_q  <= tick && midnight;
         unique case (state_q)
            ST_RUN: begin
               blank_q <= 4'b0000;
               dot_q   <= dot_run;
               if (i_Set_Pulse) begin
                  state_q <= ST_SET_HOUR;
                  presc_q <= '0;
               end else begin
                  presc_q <= tick ? '0 : presc_q + PW'(1);
               end
            end
            ST_SET_HOUR: begin
               blank_q <= {blink, blink, 2'b00};
               dot_q   <= 1'b1;
               presc_q <= '0;
               if (i_Set_Pulse)
                  state_q <= ST_SET_MIN;
            end
            ST_SET_MIN: begin
               blank_q <= {2'b00, blink, blink};
               dot_q   <= 1'b1;
               presc_q <= '0;
               if (i_Set_Pulse)
                  state_q <= ST_RUN;
            end
            default: begin
               blank_q <= 4'b0000;
               dot_q   <= 1'b0;
               presc_q <= '0;
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign hour_disp      = (HOUR_12 != 0) ? hour_12h(hour_q) : hour_q;
   assign o_Hour_Tens    = hour_disp[5:4];
   assign o_Hour_Units   = hour_disp[3:0];
   assign o_Min_Tens     = min_q[6:4];
   assign o_Min_Units    = min_q[3:0];
   assign o_Sec_Tens     = sec_q[6:4];
   assign o_Sec_Units    = sec_q[3:0];
   assign o_PM           = (HOUR_12 != 0) && (hour_q >= BCD_NOON);
   assign o_Blank_Digits = blank_q;
   assign o_Dot          = dot_q;
   assign o_Tick_1Hz     = tick_q;
   assign o_Day_Tick     = day_q;
   assign o_Setting      = state_q != ST_RUN;

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper: randomized and directed bench, 24h and 12h
// instances checked each cycle against a seconds-of-day model.
module tb_clock_timekeeper;

   localparam int F = 8;
   localparam int D = 6;
   localparam int P = 2;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic set_p  = 1'b0;
   logic up     = 1'b0;
   logic cmp_en = 1'b0;

   logic [1:0] ht [2];
   logic [3:0] hu [2];
   logic [2:0] mt [2];
   logic [3:0] mu [2];
   logic [2:0] st [2];
   logic [3:0] su [2];
   logic       pm [2];
   logic [3:0] blank [2];
   logic       dot [2];
   logic       tk [2];
   logic       day [2];
   logic       setting [2];

   int n_chk  = 0;
   int n_fail = 0;

   int m_h, m_m, m_s, m_pre, m_mode, m_held, m_ev;
   int e_tick, e_day, e_blank, e_dot;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      clock_timekeeper #(
         .CLK_FREQ_HZ       (F),
         .HOUR_12           (g),
         .REPEAT_DELAY_CYC  (D),
         .REPEAT_PERIOD_CYC (P)
      ) u_dut (
         .i_Clock        (clk),
         .i_Reset_n      (rst_n),
         .i_Set_Pulse    (set_p),
         .i_Up_Level     (up),
         .o_Hour_Tens    (ht[g]),
         .o_Hour_Units   (hu[g]),
         .o_Min_Tens     (mt[g]),
         .o_Min_Units    (mu[g]),
         .o_Sec_Tens     (st[g]),
         .o_Sec_Units    (su[g]),
         .o_PM           (pm[g]),
         .o_Blank_Digits (blank[g]),
         .o_Dot          (dot[g]),
         .o_Tick_1Hz     (tk[g]),
         .o_Day_Tick     (day[g]),
         .o_Setting      (setting[g])
      );
   end

   function automatic int disp12(input int h);
      if (h == 0) return 12;
      if (h > 12) return h - 12;
      return h;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0;
      m_pre = 0; m_mode = 0;
      m_held = -1; m_ev = 0;
      e_tick = 0; e_day = 0; e_blank = 0; e_dot = 0;
   endtask

   // One clock edge of the reference, from the rules directly
   task automatic model_step();
      int t;
      bit tkn, ph;
      tkn = (m_mode == 0) && (m_pre == F - 1);
      ph = (m_pre % (F / 2)) >= (F / 4);
      e_tick = int'(tkn);
      e_day = int'(tkn && m_h == 23 && m_m == 59 && m_s == 59);
      e_blank = !ph ? 0 : (m_mode == 1) ? 12 : (m_mode == 2) ? 3 : 0;
      e_dot = (m_mode != 0) ? 1 : int'(m_pre < F / 2);
      if (tkn) begin
         t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
         m_h = t / 3600;
         m_m = (t / 60) % 60;
         m_s = t % 60;
      end
      case (m_mode)
         0: begin
            if (set_p) begin m_mode = 1; m_pre = 0; end
            else m_pre = (m_pre + 1) % F;
         end
         1: begin
            m_pre = 0;
            if (set_p) m_mode = 2;
            else if (m_ev != 0) m_h = (m_h + 1) % 24;
         end
         default: begin
            m_pre = 0;
            if (set_p) begin m_mode = 0; m_s = 0; end
            else if (m_ev != 0) m_m = (m_m + 1) % 60;
         end
      endcase
      if (up) begin
         m_held++;
         m_ev = int'(m_held == 0 ||
                (m_held >= D && (m_held - D) % P == 0));
      end else begin
         m_held = -1;
         m_ev = 0;
      end
   endtask

   task automatic compare_all();
      int hd;
      for (int i = 0; i < 2; i++) begin
         hd = (i == 1) ? disp12(m_h) : m_h;
         chk($sformatf("u%0d_hour_t", i), int'(ht[i]), hd / 10);
         chk($sformatf("u%0d_hour_u", i), int'(hu[i]), hd % 10);
         chk($sformatf("u%0d_min_t", i), int'(mt[i]), m_m / 10);
         chk($sformatf("u%0d_min_u", i), int'(mu[i]), m_m % 10);
         chk($sformatf("u%0d_sec_t", i), int'(st[i]), m_s / 10);
         chk($sformatf("u%0d_sec_u", i), int'(su[i]), m_s % 10);
         chk($sformatf("u%0d_pm", i), int'(pm[i]),
             int'(i == 1 && m_h >= 12));
         chk($sformatf("u%0d_blank", i), int'(blank[i]), e_blank);
         chk($sformatf("u%0d_dot", i), int'(dot[i]), e_dot);
         chk($sformatf("u%0d_tick", i), int'(tk[i]), e_tick);
         chk($sformatf("u%0d_day", i), int'(day[i]), e_day);
         chk($sformatf("u%0d_setting", i), int'(setting[i]),
             int'(m_mode != 0));
      end
   endtask

   always @(posedge clk) if (rst_n) model_step();
   always @(negedge rst_n) model_reset();
   always @(negedge clk) if (cmp_en) compare_all();

   function automatic int hr(input int i);
      return int'(ht[i]) * 10 + int'(hu[i]);
   endfunction

   function automatic int mn(input int i);
      return int'(mt[i]) * 10 + int'(mu[i]);
   endfunction

   function automatic int sc(input int i);
      return int'(st[i]) * 10 + int'(su[i]);
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_set();
      set_p = 1'b1;
      step();
      set_p = 1'b0;
   endtask

   task automatic press();
      up = 1'b1;
      step();
      up = 1'b0;
      step();
   endtask

   task automatic hour_to(input int h);
      for (int k = 0; k < 30 && m_h != h; k++) press();
      chk("reach_hour", hr(0), h);
   endtask

   task automatic min_to(input int mi);
      for (int k = 0; k < 70 && m_m != mi; k++) press();
      chk("reach_min", mn(0), mi);
   endtask

   task automatic chk_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_hour"}, hr(i), (i == 1) ? 12 : 0);
         chk({tag, "_min"}, mn(i), 0);
         chk({tag, "_sec"}, sc(i), 0);
         chk({tag, "_pm"}, int'(pm[i]), 0);
         chk({tag, "_blank"}, int'(blank[i]), 0);
         chk({tag, "_dot"}, int'(dot[i]), 0);
         chk({tag, "_tick"}, int'(tk[i]), 0);
         chk({tag, "_day"}, int'(day[i]), 0);
         chk({tag, "_setting"}, int'(setting[i]), 0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset("async_rst");
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   int n, nt, nd;
   int ck [5] = '{1, 2, 7, 8, 12};
   int cv [5] = '{58, 59, 59, 0, 2};

   initial begin
      model_reset();
      repeat (3) step();
      chk_reset("por");
      cmp_en = 1'b1;
      rst_n = 1'b1;

      // Random set/up traffic
      for (int k = 0; k < 400; k++) begin
         set_p = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) up = ~up;
         step();
      end
      set_p = 1'b0;
      up = 1'b0;
      step();

      // Set flow from 00:00:xx to 03:02:00
      do_reset();
      repeat (5) step();
      pulse_set();
      repeat (3) press();
      pulse_set();
      repeat (2) press();
      pulse_set();
      chk("setflow_hour", hr(0), 3);
      chk("setflow_min", mn(0), 2);
      chk("setflow_sec", sc(0), 0);
      chk("setflow_setting", int'(setting[0]), 0);
      chk("model_pin_h", m_h, 3);
      n = 0;
      while (n < 20 && !tk[0]) begin step(); n++; end
      chk("first_tick_latency", n, 8);

      // Preset 23:59:59 and roll over
      pulse_set();
      hour_to(23);
      pulse_set();
      min_to(59);
      pulse_set();
      for (int k = 0; k < 1000; k++) begin
         if (m_h == 23 && m_m == 59 && m_s == 59) break;
         step();
      end
      chk("pre_roll_hour", hr(0), 23);
      chk("pre_roll_min", mn(0), 59);
      chk("pre_roll_sec", sc(0), 59);
      nt = 0;
      nd = 0;
      repeat (8) begin
         step();
         nt += int'(tk[0]);
         nd += int'(day[0]);
      end
      chk("roll_ticks", nt, 1);
      chk("roll_days", nd, 1);
      chk("roll_hour", hr(0), 0);
      chk("roll_min", mn(0), 0);
      chk("roll_sec", sc(0), 0);
      chk("roll_hour12", hr(1), 12);

      // Autorepeat in SET_MIN from 58
      pulse_set();
      pulse_set();
      min_to(58);
      up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         for (int j = 0; j < 5; j++)
            if (ck[j] == k)
               chk($sformatf("rep_min_k%0d", k), mn(0), cv[j]);
      end
      up = 1'b0;
      chk("rep_hour", hr(0), 0);
      chk("model_pin_m", m_m, 2);
      step();

      // Set pulse coinciding with an increment event
      pulse_set();
      pulse_set();
      up = 1'b1;
      step();
      set_p = 1'b1;
      up = 1'b0;
      step();
      set_p = 1'b0;
      chk("coll_setting", int'(setting[0]), 1);
      chk("coll_hour", hr(0), 0);
      chk("coll_min", mn(0), 2);
      press();
      chk("coll_next_min", mn(0), 3);
      chk("coll_next_hour", hr(0), 0);

      // 12-hour display
      pulse_set();
      pulse_set();
      hour_to(13);
      chk("h12_disp13", hr(1), 1);
      chk("h12_pm13", int'(pm[1]), 1);
      chk("h24_pm13", int'(pm[0]), 0);
      hour_to(0);
      chk("h12_disp0", hr(1), 12);
      chk("h12_pm0", int'(pm[1]), 0);

      // Async reset mid-edit at 14:37
      hour_to(14);
      pulse_set();
      min_to(37);
      chk("pre_rst_setting", int'(setting[0]), 1);
      do_reset();
      step();
      chk("post_rst_setting", int'(setting[0]), 0);
      repeat (20) step();

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
